// File: rtl/cdc_fifo_src_clear_seq.sv
// rtl/cdc_fifo_src_clear_seq.sv - source-side stream register and clear sequencer for the clearable CDC FIFO
// Optional statistics counters: define CDC_FIFO_SRC_CLEAR_SEQ_STATS_EN.
module cdc_fifo_src_clear_seq #(
  parameter int  WIDTH       = 8,
  parameter type T           = logic [WIDTH-1:0],
  parameter int  ACK_TIMEOUT = 16,
  parameter int  CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  output logic                 clear_timeout_o,
  input  T                     in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output T                     out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 fifo_clear_o,
  input  logic                 fifo_clear_pending_i,
  output logic [CNT_WIDTH-1:0] clear_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic          req_q;
  logic          valid_q;
  T              data_q;
  logic [TW-1:0] timer;
  logic          in_fire;
  logic          out_fire;
  logic          flush_hit;
  logic          clear_end;

  // The register keeps its beat while busy so ISSUE can see and count it;
  // the outside world only sees it while IDLE.
  assign out_valid_o  = valid_q & (state == IDLE);
  assign out_data_o   = data_q;
  assign in_ready_o   = (state == IDLE) & ~req_q & (~out_valid_o | out_ready_i);
  assign in_fire      = in_valid_i & in_ready_o;
  assign out_fire     = out_valid_o & out_ready_i;
  assign fifo_clear_o = (state == ISSUE) & ~fifo_clear_pending_i;
  assign clear_busy_o = (state != IDLE);
  assign flush_hit    = (state != IDLE) & valid_q;
  assign clear_end    = (state == WAIT_DONE) & ~fifo_clear_pending_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      req_q           <= 1'b0;
      valid_q         <= 1'b0;
      data_q          <= '0;
      timer           <= '0;
      clear_done_o    <= 1'b0;
      clear_timeout_o <= 1'b0;
    end else begin
      clear_done_o <= 1'b0;

      if (state == IDLE) begin
        if (in_fire) begin
          data_q  <= in_data_i;
          valid_q <= 1'b1;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end else begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end

      case (state)
        IDLE: begin
          // A clear already in flight from the far side takes precedence;
          // a simultaneous local request is replayed once it finishes.
          if (fifo_clear_pending_i) begin
            state <= WAIT_DONE;
            if (clear_req_i) req_q <= 1'b1;
          end else if (clear_req_i || req_q) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          req_q <= 1'b0;
          timer <= '0;
          state <= fifo_clear_pending_i ? WAIT_DONE : WAIT_ACK;
        end
        WAIT_ACK: begin
          if (fifo_clear_pending_i) begin
            state <= WAIT_DONE;
          end else if (timer == TMAX) begin
            state           <= IDLE;
            clear_timeout_o <= 1'b1;
            clear_done_o    <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (clear_req_i) req_q <= 1'b1;
          if (!fifo_clear_pending_i) begin
            state        <= IDLE;
            clear_done_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDC_FIFO_SRC_CLEAR_SEQ_STATS_EN
  logic [CNT_WIDTH-1:0] clear_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clear_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (clear_end && (clear_cnt != '1)) clear_cnt <= clear_cnt + 1'b1;
      if (flush_hit && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign clear_count_o = clear_cnt;
  assign flush_count_o = flush_cnt;
`else
  logic stats_unused;
  assign stats_unused  = clear_end ^ flush_hit;
  assign clear_count_o = '0;
  assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_cdc_fifo_src_clear_seq.sv
// tb/tb_cdc_fifo_src_clear_seq.sv - directed bench with a queue model for cdc_fifo_src_clear_seq
module tb_cdc_fifo_src_clear_seq;
  localparam int WIDTH       = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_WIDTH   = 16;
`ifdef CDC_FIFO_SRC_CLEAR_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear_req = 1'b0;
  logic                 clear_busy_o, clear_done_o, clear_timeout_o;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     out_data_o;
  logic                 out_valid_o;
  logic                 out_ready = 1'b0;
  logic                 fifo_clear_o;
  logic                 pending = 1'b0;
  logic [CNT_WIDTH-1:0] clear_count_o, flush_count_o;

  always #5 clk = ~clk;

  cdc_fifo_src_clear_seq #(
    .WIDTH(WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_req_i(clear_req),
    .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o), .clear_timeout_o(clear_timeout_o),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .fifo_clear_o(fifo_clear_o), .fifo_clear_pending_i(pending),
    .clear_count_o(clear_count_o), .flush_count_o(flush_count_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Model: the output register holds at most one accepted, undelivered beat.
  // A clear discards whatever is queued at the moment busy rises.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] prev_data;
  int  cyc = 0;
  int  delivered, clear_pulses, done_cnt, m_flush, m_clears, run_len, max_run;
  int  last_clear_cyc, last_done_cyc, first_to_cyc;
  bit  prev_busy, prev_stall, saw_pend;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      prev_busy = 0; prev_stall = 0; saw_pend = 0;
      delivered = 0; clear_pulses = 0; done_cnt = 0; m_flush = 0; m_clears = 0;
      run_len = 0; max_run = 0; last_clear_cyc = 0; last_done_cyc = 0; first_to_cyc = -1;
    end else begin
      if (clear_busy_o && !prev_busy) begin
        m_flush += q.size();
        q.delete();
      end
      if (clear_busy_o && pending) saw_pend = 1;
      if (clear_busy_o) begin
        chk("busy_in_ready", in_ready_o, 0);
        chk("busy_out_valid", out_valid_o, 0);
      end else begin
        chk("out_valid_vs_model", out_valid_o, q.size() != 0);
        if (prev_stall && out_valid_o) chk("stall_data_stable", out_data_o, prev_data);
        if (out_valid_o && out_ready) begin
          chk("model_has_beat", q.size() != 0, 1);
          if (q.size() != 0) begin
            chk("out_data_order", out_data_o, q.pop_front());
            delivered++;
          end
        end
        if (in_valid && in_ready_o) q.push_back(in_data);
      end
      if (fifo_clear_o) begin
        chk("clear_while_pending", pending, 0);
        chk("clear_outside_busy", clear_busy_o, 1);
        clear_pulses++;
        last_clear_cyc = cyc;
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (clear_done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (saw_pend) m_clears++;
        saw_pend = 0;
      end
      if (clear_timeout_o && first_to_cyc < 0) first_to_cyc = cyc;
      prev_stall = out_valid_o && !out_ready;
      prev_data  = out_data_o;
      prev_busy  = clear_busy_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; clear_req = 0; in_valid = 0; out_ready = 0; pending = 0;
    step(); step();
    rst = 0;
    step();
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit rand_ready);
    int  n;
    bit  acc;
    n = 0;
    in_data = d; in_valid = 1;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_ready_o;
      step();
      n++;
    end while (!acc && n < 100);
    in_valid = 0;
    if (!acc) chk("send_accept_bound", acc, 1);
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!clear_done_o && n < bound) begin
      step();
      n++;
    end
    chk(name, clear_done_o, 1);
    step();
  endtask

  task automatic pulse_req();
    clear_req = 1;
    step();
    clear_req = 0;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_fifo_clear", fifo_clear_o, 0);
    chk("rst_busy", clear_busy_o, 0);
    chk("rst_done", clear_done_o, 0);
    chk("rst_timeout", clear_timeout_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_clear_count", clear_count_o, 0);
    chk("rst_flush_count", flush_count_o, 0);
    step();
    rst = 0;
    step();

    // 16 beats through the register under random back-pressure
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 1'b1);
    out_ready = 1;
    step(); step(); step();
    chk("stream_delivered", delivered, 16);
    chk("stream_queue_empty", q.size(), 0);

    // local clear with a stalled beat in the register
    do_reset();
    send(8'h5A, 1'b0);
    chk("s2_stalled_valid", out_valid_o, 1);
    chk("s2_stalled_data", out_data_o, 8'h5A);
    pulse_req();
    chk("s2_issue_clear", fifo_clear_o, 1);
    chk("s2_issue_valid_low", out_valid_o, 0);
    step();
    chk("s2_clear_one_cycle", fifo_clear_o, 0);
    pending = 1;
    step(); step(); step();
    pending = 0;
    wait_done("s2_done_seen", 10);
    chk("s2_clear_run", max_run, 1);
    chk("s2_clear_pulses", clear_pulses, 1);
    chk("s2_done_pulses", done_cnt, 1);
    chk("s2_model_flush", m_flush, 1);
    chk("s2_model_clears", m_clears, 1);
    chk("s2_flush_count", flush_count_o, STATS ? m_flush : 0);
    chk("s2_clear_count", clear_count_o, STATS ? m_clears : 0);

    // remote clear: pending rises with no local request
    do_reset();
    out_ready = 1;
    pending = 1;
    step();
    chk("s3_busy", clear_busy_o, 1);
    chk("s3_in_ready", in_ready_o, 0);
    step(); step();
    pending = 0;
    wait_done("s3_done_seen", 10);
    chk("s3_no_fifo_clear", clear_pulses, 0);
    chk("s3_done_pulses", done_cnt, 1);
    chk("s3_in_ready_back", in_ready_o, 1);
    chk("s3_clear_count", clear_count_o, STATS ? 1 : 0);

    // request during WAIT_DONE replays one cycle after the return to IDLE
    do_reset();
    pulse_req();
    step();
    pending = 1;
    step();
    chk("s4_wait_done", clear_busy_o, 1);
    clear_req = 1;
    step();
    clear_req = 0;
    step();
    pending = 0;
    wait_done("s4_first_done", 10);
    step();
    chk("s4_reissue_gap", last_clear_cyc - last_done_cyc, 1);
    pending = 1;
    step(); step();
    pending = 0;
    wait_done("s4_second_done", 10);
    chk("s4_clear_pulses", clear_pulses, 2);
    chk("s4_model_clears", m_clears, 2);
    chk("s4_clear_count", clear_count_o, STATS ? 2 : 0);

    // acknowledge never arrives
    do_reset();
    pulse_req();
    for (int i = 0; i < 40 && !clear_timeout_o; i++) step();
    step();
    chk("s5_timeout", clear_timeout_o, 1);
    chk("s5_timeout_latency", first_to_cyc - last_clear_cyc, ACK_TIMEOUT + 1);
    chk("s5_idle", clear_busy_o, 0);
    chk("s5_done_pulses", done_cnt, 1);
    chk("s5_clear_count", clear_count_o, 0);
    step(); step();
    chk("s5_timeout_sticky", clear_timeout_o, 1);

    // reset while waiting for the acknowledge
    do_reset();
    pulse_req();
    step(); step();
    chk("s6_in_wait_ack", clear_busy_o, 1);
    rst = 1;
    #1;
    chk("s6_rst_busy", clear_busy_o, 0);
    chk("s6_rst_fifo_clear", fifo_clear_o, 0);
    chk("s6_rst_timeout", clear_timeout_o, 0);
    chk("s6_rst_in_ready", in_ready_o, 1);
    step();
    rst = 0;
    for (int i = 0; i < 25; i++) step();
    chk("s6_no_later_clear", clear_pulses, 0);
    chk("s6_no_timeout", clear_timeout_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
